// File: rtl/servo_pwm_pkg.sv
// rtl/servo_pwm_pkg.sv - shared defaults and types for the multi-channel servo PWM
package servo_pwm_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_PERIOD      = 1_000_000;
    localparam int DEF_MIN_PULSE   = 75_000;
    localparam int DEF_STEP_CYCLES = 750;
    localparam int DEF_POS_W       = 8;
    localparam int DEF_POS_MAX     = 100;
    localparam int DEF_HOME_POS    = 50;
    localparam int DEF_SLEW        = 2;

    typedef logic [DEF_POS_W-1:0] pos_t;

    // Channel-index width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// rtl/servo_slew_ch.sv - one servo channel: target, slew-limited position, width, compare
module servo_slew_ch
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int POS_W       = DEF_POS_W,
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int HOME_POS    = DEF_HOME_POS,
    parameter int SLEW        = DEF_SLEW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [POS_W-1:0] wr_pos,
    input  logic             step_en,
    input  logic             load_en,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm,
    output logic             busy
);

    localparam logic [POS_W-1:0] HOME_V     = POS_W'(HOME_POS);
    localparam logic [POS_W-1:0] SLEW_V     = POS_W'(SLEW);
    localparam logic [CNT_W-1:0] HOME_WIDTH = CNT_W'(MIN_PULSE + HOME_POS * STEP_CYCLES);

    logic [POS_W-1:0] target;
    logic [POS_W-1:0] cur;
    logic [POS_W-1:0] cur_next;
    logic [POS_W-1:0] gap;
    logic [CNT_W-1:0] width;

    assign busy = (cur != target);

    // Next position: move toward target by at most SLEW, or jump when SLEW is 0.
    always_comb begin
        cur_next = cur;
        gap      = '0;
        if (target > cur) begin
            gap      = target - cur;
            cur_next = (SLEW == 0 || gap <= SLEW_V) ? target : cur + SLEW_V;
        end else if (target < cur) begin
            gap      = cur - target;
            cur_next = (SLEW == 0 || gap <= SLEW_V) ? target : cur - SLEW_V;
        end
    end

    // Position/width registers update only at the frame tail, so a pulse never sees a width change.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= HOME_V;
            cur    <= HOME_V;
            width  <= HOME_WIDTH;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) begin
                target <= wr_pos;
            end
            if (step_en) begin
                cur <= cur_next;
            end
            if (load_en) begin
                width <= CNT_W'(MIN_PULSE) + CNT_W'(cur) * CNT_W'(STEP_CYCLES);
            end
            pwm <= en && (cnt < width);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM with shared frame counter and write port
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int PERIOD_CYCLES = DEF_PERIOD,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter int POS_W         = DEF_POS_W,
    parameter int POS_MAX       = DEF_POS_MAX,
    parameter int HOME_POS      = DEF_HOME_POS,
    parameter int SLEW          = DEF_SLEW,
    localparam int CH_W         = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(PERIOD_CYCLES - 2);
    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);

    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              ch_ok;
    logic [POS_W-1:0]  pos_clamped;
    logic              step_en;
    logic              load_en;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_busy;

    assign accept      = wr_valid && wr_ready;
    assign ch_ok       = ({1'b0, wr_ch} < NUM_CH_V);
    assign pos_clamped = (wr_pos > POS_MAX_V) ? POS_MAX_V : wr_pos;
    assign step_en     = en && (cnt == CNT_STEP);
    assign load_en     = en && (cnt == CNT_LAST);

    // One-hot write strobe for the addressed channel; illegal indices strobe nothing.
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = accept && ch_ok && (wr_ch == CH_W'(i));
        end
    end

    // Shared frame counter; disabling parks it at 0 so re-enable starts a fresh frame.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered handshake, error pulse, frame tick and aggregate busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ready   <= 1'b0;
            wr_err     <= 1'b0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_ready   <= 1'b1;
            wr_err     <= accept && !ch_ok;
            frame_tick <= en && (cnt == '0);
            busy       <= |ch_busy;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_slew_ch #(
            .CNT_W       (CNT_W),
            .POS_W       (POS_W),
            .MIN_PULSE   (MIN_PULSE),
            .STEP_CYCLES (STEP_CYCLES),
            .HOME_POS    (HOME_POS),
            .SLEW        (SLEW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wr_en   (ch_wr[g]),
            .wr_pos  (pos_clamped),
            .step_en (step_en),
            .load_en (load_en),
            .cnt     (cnt),
            .pwm     (pwm_out[g]),
            .busy    (ch_busy[g])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - scoreboard bench for servo_pwm_multi
module tb_servo_pwm_multi;

    localparam int NCH   = 4;
    localparam int P     = 100;
    localparam int MINP  = 10;
    localparam int STEPC = 2;
    localparam int PMAX  = 20;
    localparam int HOME  = 10;
    localparam int SL    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_pos = '0;
    logic       wr_ready, wr_err, frame_tick, busy;
    logic [3:0] pwm_out;

    logic       wr_valid5 = 1'b0;
    logic [2:0] wr_ch5 = 3'd5;
    logic       wr_ready5, wr_err5, tick5, busy5;
    logic [4:0] pwm5;

    servo_pwm_multi #(
        .NUM_CH(NCH), .CNT_W(20), .PERIOD_CYCLES(P), .MIN_PULSE(MINP), .STEP_CYCLES(STEPC),
        .POS_W(8), .POS_MAX(PMAX), .HOME_POS(HOME), .SLEW(SL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_pos(wr_pos), .wr_err(wr_err), .pwm_out(pwm_out),
        .frame_tick(frame_tick), .busy(busy)
    );

    // Five-channel copy: its 3-bit index can express illegal channels 5..7.
    servo_pwm_multi #(
        .NUM_CH(5), .CNT_W(20), .PERIOD_CYCLES(P), .MIN_PULSE(MINP), .STEP_CYCLES(STEPC),
        .POS_W(8), .POS_MAX(PMAX), .HOME_POS(HOME), .SLEW(SL)
    ) dut5 (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid5), .wr_ready(wr_ready5),
        .wr_ch(wr_ch5), .wr_pos(wr_pos), .wr_err(wr_err5), .pwm_out(pwm5),
        .frame_tick(tick5), .busy(busy5)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (values as seen after the latest clock edge).
    int m_cnt = 0;
    int m_tgt[NCH];
    int m_cur[NCH];
    int m_wid[NCH];
    bit m_ready, m_err, m_err5, m_tick, m_busy, m_zero, m_valid = 1'b0;
    int exp_q[NCH][$];

    task automatic truncate(input int ch, input int k);
        if (exp_q[ch].size() > 0) exp_q[ch][exp_q[ch].size() - 1] = k;
    endtask

    // Model: positions, frame position and expected pulse widths from the behavioural rules.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_valid && m_cnt > 0 && m_cnt < m_wid[i]) truncate(i, m_cnt);
                m_tgt[i] = HOME;
                m_cur[i] = HOME;
                m_wid[i] = MINP + HOME * STEPC;
            end
            m_cnt = 0; m_ready = 0; m_err = 0; m_err5 = 0; m_tick = 0; m_busy = 0;
            m_zero = 1; m_valid = 1;
        end else if (m_valid) begin
            bit busy_n;
            busy_n = 0;
            for (int i = 0; i < NCH; i++) if (m_cur[i] != m_tgt[i]) busy_n = 1;
            m_err  = wr_valid && m_ready && (int'(wr_ch) >= NCH);
            m_err5 = wr_valid5 && m_ready && (int'(wr_ch5) >= 5);
            m_tick = en && (m_cnt == 0);
            m_zero = !en;
            for (int i = 0; i < NCH; i++) begin
                if (en && m_cnt == 0) begin
                    chk($sformatf("pulse_pending_ch%0d", i), exp_q[i].size(), 0);
                    exp_q[i].push_back(m_wid[i]);
                end
                if (!en && m_cnt > 0 && m_cnt < m_wid[i]) truncate(i, m_cnt);
                if (en && m_cnt == P - 1) m_wid[i] = MINP + m_cur[i] * STEPC;
                if (en && m_cnt == P - 2) begin
                    int d;
                    d = m_tgt[i] - m_cur[i];
                    if (SL == 0 || (d <= SL && d >= -SL)) m_cur[i] = m_tgt[i];
                    else m_cur[i] = m_cur[i] + ((d > 0) ? SL : -SL);
                end
            end
            if (wr_valid && m_ready && int'(wr_ch) < NCH)
                m_tgt[wr_ch] = (int'(wr_pos) > PMAX) ? PMAX : int'(wr_pos);
            m_cnt   = en ? ((m_cnt == P - 1) ? 0 : m_cnt + 1) : 0;
            m_busy  = busy_n;
            m_ready = 1;
        end
    end

    // Monitor: per-cycle flags, plus pulse widths popped from the scoreboard on each falling edge.
    int hl[NCH];
    bit prev[NCH];
    initial begin
        for (int i = 0; i < NCH; i++) begin hl[i] = 0; prev[i] = 0; end
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("wr_ready", wr_ready, m_ready);
                chk("wr_ready5", wr_ready5, m_ready);
                chk("wr_err", wr_err, m_err);
                chk("wr_err5", wr_err5, m_err5);
                chk("frame_tick", frame_tick, m_tick);
                chk("frame_tick5", tick5, m_tick);
                chk("busy", busy, m_busy);
                chk("busy5_illegal_only", busy5, 0);
                if (m_zero) chk("pwm_forced_low", pwm_out, 0);
                for (int i = 0; i < NCH; i++) begin
                    if (pwm_out[i] && !prev[i]) chk($sformatf("rise_tick_ch%0d", i), frame_tick, 1);
                    if (pwm_out[i]) hl[i]++;
                    else if (hl[i] > 0) begin
                        if (exp_q[i].size() == 0) chk($sformatf("unexpected_pulse_ch%0d", i), hl[i], 0);
                        else chk($sformatf("pulse_width_ch%0d", i), hl[i], exp_q[i].pop_front());
                        hl[i] = 0;
                    end
                    prev[i] = pwm_out[i];
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int c);
        int t;
        t = 0;
        while (m_cnt != c && t < 3 * P) begin @(negedge clk); t++; end
        if (t >= 3 * P) chk("wait_cnt_timeout", m_cnt, c);
    endtask

    task automatic write(input int ch, input int pos);
        wr_valid = 1; wr_ch = 2'(ch); wr_pos = 8'(pos);
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic write5(input int ch);
        wr_valid5 = 1; wr_ch5 = 3'(ch); wr_pos = 8'd3;
        @(negedge clk);
        wr_valid5 = 0;
    endtask

    initial begin
        cycles(3);
        rst = 0;
        cycles(3 * P);                          // home widths, ticks, busy low
        write(1, 19);  cycles(5 * P);           // 36, 42, 48, 48
        write(2, 200); write5(5); cycles(5 * P);
        wait_cnt(98);  write(0, 0); cycles(4 * P);
        wait_cnt(10);  en = 0; cycles(20);      // abort mid-pulse
        write(3, 0);   cycles(20);              // accepted while disabled
        en = 1;        cycles(3 * P);
        wait_cnt(5);   rst = 1; cycles(2); rst = 0;
        cycles(3 * P);
        for (int c = 0; c < 2500; c++) begin
            wr_valid  = ($urandom_range(0, 15) == 0);
            wr_ch     = 2'($urandom_range(0, 3));
            wr_pos    = 8'($urandom_range(0, 255));
            wr_valid5 = ($urandom_range(0, 31) == 0);
            wr_ch5    = 3'($urandom_range(5, 7));
            rst       = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 399) == 0) en = !en;
            @(negedge clk);
        end
        wr_valid = 0; wr_valid5 = 0; rst = 0; en = 1;
        cycles(2 * P);
        en = 0;
        cycles(5);
        for (int i = 0; i < NCH; i++) chk($sformatf("queue_drained_ch%0d", i), exp_q[i].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Multi-channel servo PWM generator for the arm joints; successor to the single-channel PWM block.
- One shared frame counter drives NUM_CH outputs, each with its own target position.
- Targets are written through a valid/ready port; adds per-frame slew limiting and glitch-free updates at frame boundaries.
- Sits between the joint-command logic and the servo output pins.

Parameters:
- NUM_CH, 4, number of servo channels.
- CNT_W, 20, frame counter and pulse-width register width.
- PERIOD_CYCLES, 1_000_000, clocks per PWM frame; must be >= 4 and > MAX pulse.
- MIN_PULSE, 75_000, pulse width in clocks at position 0.
- STEP_CYCLES, 750, clocks added per position unit; position POS_MAX gives MIN_PULSE + POS_MAX*STEP_CYCLES = 150_000.
- POS_W, 8, position field width.
- POS_MAX, 100, largest legal position.
- HOME_POS, 50, reset position of every channel.
- SLEW, 2, maximum position change per frame; 0 means an immediate jump.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, global output enable.
- wr_valid, in, 1, target write request.
- wr_ready, out, 1, write accept.
- wr_ch, in, clog2(NUM_CH) (min 1), channel index.
- wr_pos, in, POS_W, target position.
- wr_err, out, 1, one-cycle pulse when a write has an illegal channel index.
- pwm_out, out, NUM_CH, servo pulses, bit i = channel i.
- frame_tick, out, 1, one-cycle pulse at the start of each frame.
- busy, out, 1, high while any channel's current position differs from its target.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt = 0; target[i] = cur[i] = HOME_POS.
  - width[i] = MIN_PULSE + HOME_POS*STEP_CYCLES.
  - pwm_out = 0, frame_tick = 0, wr_err = 0, wr_ready = 0, busy = 0.
- wr_ready = !rst, registered; it is 1 from the first cycle after reset deasserts.
- A write is accepted when wr_valid && wr_ready.
  - wr_pos > POS_MAX is clamped to POS_MAX.
  - wr_ch >= NUM_CH: no state change; wr_err pulses 1 in the next cycle.
  - A write updates target[wr_ch] at the clock edge; en has no effect on writes.
- Frame counter:
  - Counts 0..PERIOD_CYCLES-1 and wraps to 0 while en=1.
  - en=0 forces cnt to 0 and pwm_out to 0, and suppresses frame_tick; targets and cur are held.
- Boundary pipeline (en=1):
  - cnt == PERIOD_CYCLES-2: each cur[i] moves toward target[i] by min(SLEW, |target-cur|); SLEW=0 sets cur = target. The step uses target as registered before this edge, so a write in that cycle is applied next frame.
  - cnt == PERIOD_CYCLES-1: width[i] = MIN_PULSE + cur[i]*STEP_CYCLES, CNT_W bits, no overflow at the stated defaults.
- Outputs (en=1):
  - pwm_out[i] is registered: pwm_out[i] <= (cnt < width[i]).
  - A pulse therefore starts one clock after cnt reaches 0 and lasts exactly width[i] clocks.
  - width never changes mid-pulse, so there are no runt or stretched pulses.
  - frame_tick is registered high in the cycle after cnt == 0, aligned with the pwm_out rising edge.
- busy = OR over i of (cur[i] != target[i]), registered.
- en rising: the frame starts at cnt = 0 with the current width; the first pulse begins one clock after en is seen high.
- Reset mid-frame aborts the pulse: pwm_out = 0 on the next edge and all positions return to HOME_POS.

Decomposition:
- Package servo_pwm_pkg holds the default constants (PERIOD, MIN_PULSE, STEP_CYCLES, POS_MAX, HOME_POS) and a position typedef of POS_W bits.
- One sub-module, servo_slew_ch, one instance per channel.
  - Holds target, cur and width for its channel.
  - Performs the step and width computation.
  - Drives the compare output.
- The top level holds cnt, the write decode, frame_tick and the busy OR.

Test Plan (bench parameters: PERIOD_CYCLES=100, MIN_PULSE=10, STEP_CYCLES=2, POS_MAX=20, HOME_POS=10, SLEW=3, NUM_CH=4):
1. Release reset with en=1 -> every channel pulses 30 clocks high and 70 low; frame_tick fires once per 100 clocks, aligned with the rising edges; busy=0.
2. Write ch1 pos 19 -> ch1 widths over successive frames are 36, 42, 48, 48 (cur 13, 16, 19); busy falls when cur reaches 19; other channels stay at 30.
3. Write ch2 pos 200 -> clamped to 20, final width 50; write ch5 -> wr_err pulses for one cycle and no channel changes.
4. Write ch0 pos 0 in the cycle where cnt=98 -> that frame's width stays 30; the next frame is 24, then 18.
5. Deassert en mid-pulse -> pwm_out=0 next cycle and frame_tick stops; a write while disabled is accepted; re-enable -> pulse begins one clock later at the held cur width.
6. Assert rst at cnt=5 during a width-48 pulse -> pwm_out=0 next edge; after release all channels pulse 30 and busy=0.
